// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = X - Y, LSB first, one full-subtractor cell.
// Optional signed-overflow output OV is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BO
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OV
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             diff_bit;
    logic             borrow_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             x_msb;
`endif

    // Returns {borrow_out, diff} for a single bit position.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic dif;
        logic bout;
        dif  = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
        return {bout, dif};
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic msb);
        logic [WIDTH-1:0] r;
        r            = v >> 1;
        r[WIDTH-1]   = msb;
        return r;
    endfunction

    assign {borrow_next, diff_bit} = full_sub(x_sr[0], y_sr[0], borrow);
    assign accept = (state == IDLE) && IN_VALID;
    assign last   = (state == RUN) && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (IN_VALID)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (OUT_READY) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs depend only on the state register.
    always_comb begin
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_sr   <= '0;
            y_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            BO     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb  <= 1'b0;
            OV     <= 1'b0;
`endif
        end else if (accept) begin
            x_sr   <= X;
            y_sr   <= Y;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb  <= X[WIDTH-1];
`endif
        end else if (state == RUN) begin
            x_sr   <= x_sr >> 1;
            y_sr   <= y_sr >> 1;
            borrow <= borrow_next;
            D      <= shift_in(D, diff_bit);
            if (last) begin
                BO <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
                // On the final bit y_sr[0] is Y's MSB and diff_bit is D's MSB.
                OV <= (x_msb ^ y_sr[0]) & (diff_bit ^ x_msb);
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at WIDTH=8.
// Checks OV as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] D;
    logic         BO;
`ifdef SERIAL_SUB_OVF_EN
    logic         OV;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .X(X), .Y(Y),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .D(D), .BO(BO)
`ifdef SERIAL_SUB_OVF_EN
        , .OV(OV)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Accept one operand pair; optionally scramble inputs after the accept edge.
    // Returns the number of edges from accept until OUT_VALID (0 on timeout).
    task automatic start_and_wait(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                  input logic scramble, output int lat);
        int n;
        n = 0;
        while (!IN_READY && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", {31'd0, IN_READY}, 32'd1);
        X = xv;
        Y = yv;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        if (scramble) begin
            X = 8'hAA;
            Y = 8'h55;
        end
        n = 0;
        while (!OUT_VALID && n < 50) begin
            tick();
            n++;
        end
        lat = OUT_VALID ? n : 0;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_d"}, {24'd0, D}, {24'd0, v.d});
        check({tag, "_bo"}, {31'd0, BO}, {31'd0, v.bo});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ov"}, {31'd0, OV}, {31'd0, v.ov});
`endif
    endtask

    initial begin
        int lat;
        vec_t v;

        vecs[0] = '{8'h09, 8'h05, 8'h04, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h09, 8'hFC, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h05, 8'h0B, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

        // Reset state
        #2;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_d", {24'd0, D}, 32'd0);
        check("rst_bo", {31'd0, BO}, 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Table-driven vectors with immediate consumption
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start_and_wait(vecs[i].x, vecs[i].y, 1'b0, lat);
            check($sformatf("latency_%0d", i), lat, 32'd8);
            check_result($sformatf("vec%0d", i), vecs[i]);
            tick();
            check($sformatf("post_hs_valid_%0d", i), {31'd0, OUT_VALID}, 32'd0);
            tick();
            check($sformatf("idle_ready_%0d", i), {31'd0, IN_READY}, 32'd1);
            check($sformatf("held_d_%0d", i), {24'd0, D}, {24'd0, vecs[i].d});
        end

        // Backpressure: hold DONE for 20 cycles while offering new operands
        OUT_READY = 1'b0;
        start_and_wait(8'h05, 8'h09, 1'b0, lat);
        check("bp_latency", lat, 32'd8);
        X = 8'h11;
        Y = 8'h22;
        IN_VALID = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!(OUT_VALID === 1'b1 && IN_READY === 1'b0 && D === 8'hFC && BO === 1'b1)) begin
                check($sformatf("bp_hold_cycle%0d", c), {OUT_VALID, IN_READY, BO, D}, {1'b1, 1'b0, 1'b1, 8'hFC});
            end else begin
                checks++;
            end
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, OUT_VALID}, 32'd0);
        check("bp_release_ready", {31'd0, IN_READY}, 32'd1);
        check("bp_release_d", {24'd0, D}, 32'h0000_00FC);
        tick();
        check("bp_stays_idle", {31'd0, IN_READY}, 32'd1);

        // Inputs changed after the accept edge must be ignored
        start_and_wait(8'h30, 8'h10, 1'b1, lat);
        check("chg_latency", lat, 32'd8);
        v = '{8'h30, 8'h10, 8'h20, 1'b0, 1'b0};
        check_result("chg", v);
        tick();
        tick();

        // Asynchronous reset in the middle of RUN
        X = 8'h55;
        Y = 8'h11;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mid_run_busy", {31'd0, IN_READY}, 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, IN_READY}, 32'd1);
        check("arst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("arst_d", {24'd0, D}, 32'd0);
        check("arst_bo", {31'd0, BO}, 32'd0);
        tick();
        RST_N = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (OUT_VALID !== 1'b0) check("no_stale_result", {31'd0, OUT_VALID}, 32'd0);
        end
        start_and_wait(8'h80, 8'h01, 1'b0, lat);
        check("post_rst_latency", lat, 32'd8);
        check_result("post_rst", vecs[4]);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
